// File: rtl/crash_course_cpu_pkg.sv
// Shared types and constants for the crash-course CPU: fetch FSM states,
// datapath widths and the opcode encodings used by the program image.
package crash_course_cpu_pkg;

  localparam int CPU_ADDR_W = 8;
  localparam int CPU_INST_W = 16;

  // Opcodes live in instr[15:12]
  localparam logic [3:0] OP_ADD     = 4'h1;
  localparam logic [3:0] OP_STORE   = 4'h9;
  localparam logic [3:0] OP_LOADIMM = 4'hA;
  localparam logic [3:0] OP_JUMP    = 4'hE;

  typedef enum logic [1:0] {
    HALTED = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2
  } fetch_state_t;

  // Build an instruction word from opcode and two 4-bit fields plus a nibble
  function automatic logic [CPU_INST_W-1:0] make_inst(input logic [3:0] op,
                                                      input logic [3:0] f1,
                                                      input logic [3:0] f2,
                                                      input logic [3:0] f3);
    return {op, f1, f2, f3};
  endfunction

endpackage

// File: rtl/crash_course_cpu_fetch_controller.sv
// Fetch controller: owns the PC, reads the combinational program memory and
// registers each instruction into a one-entry valid/ready stage for decode.
// Provides run/halt/single-step control and PC redirects from execute.
module crash_course_cpu_fetch_controller
  import crash_course_cpu_pkg::*;
#(
  parameter int                ADDR_W   = CPU_ADDR_W,
  parameter int                INST_W   = CPU_INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                COUNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run_req,
  input  logic               halt_req,
  input  logic               step_req,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic [ADDR_W-1:0]  pmem_addr,
  input  logic [INST_W-1:0]  pmem_data,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [INST_W-1:0]  inst_data,
  output logic [ADDR_W-1:0]  inst_pc,
  output logic               halted,
  output logic [COUNT_W-1:0] fetch_count
);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               valid_q, valid_d;
  logic [INST_W-1:0]  data_q, data_d;
  logic [ADDR_W-1:0]  ipc_q, ipc_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               slot_free;
  logic               fetch_en;

  // Fetch qualifier: the stage must be empty or draining, the FSM must be
  // issuing, and a redirect always suppresses the fetch in its cycle.
  always_comb begin
    slot_free = !valid_q || inst_ready;
    fetch_en  = slot_free && (state_q == RUN || state_q == STEP) && !redirect_valid;
  end

  // Run/halt/step next state; a redirect cycle leaves the state untouched.
  always_comb begin
    state_d = state_q;
    if (!redirect_valid) begin
      case (state_q)
        HALTED: begin
          if (halt_req)      state_d = HALTED;
          else if (run_req)  state_d = RUN;
          else if (step_req) state_d = STEP;
        end
        RUN: begin
          if (halt_req) state_d = HALTED;
        end
        STEP: begin
          // Either the single fetch happened or the step was cancelled
          if (halt_req || fetch_en) state_d = HALTED;
        end
        default: state_d = HALTED;
      endcase
    end
  end

  // Datapath next state: redirect flushes, fetch loads, accept drains.
  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    data_d  = data_q;
    ipc_d   = ipc_q;
    count_d = count_q;
    if (redirect_valid) begin
      pc_d    = redirect_target;
      valid_d = 1'b0;
    end else if (fetch_en) begin
      data_d  = pmem_data;
      ipc_d   = pc_q;
      valid_d = 1'b1;
      pc_d    = pc_q + ADDR_W'(1);
      count_d = count_q + COUNT_W'(1);
    end else if (valid_q && inst_ready) begin
      valid_d = 1'b0;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HALTED;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      data_q  <= '0;
      ipc_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ipc_q   <= ipc_d;
      count_q <= count_d;
    end
  end

  assign pmem_addr   = pc_q;
  assign inst_valid  = valid_q;
  assign inst_data   = data_q;
  assign inst_pc     = ipc_q;
  assign halted      = (state_q == HALTED);
  assign fetch_count = count_q;

endmodule

// File: tb/tb_crash_course_cpu_fetch_controller.sv
// Bench for the fetch controller: a Fib-style program ROM feeds pmem_data,
// a scoreboard queue holds expected {pc,instr} for every accepted transfer.
module tb_crash_course_cpu_fetch_controller;
  import crash_course_cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic        run_req, halt_req, step_req;
  logic        redirect_valid;
  logic [7:0]  redirect_target;
  logic [7:0]  pmem_addr;
  logic [15:0] pmem_data;
  logic        inst_valid, inst_ready;
  logic [15:0] inst_data;
  logic [7:0]  inst_pc;
  logic        halted;
  logic [15:0] fetch_count;

  logic [15:0] rom [256];
  logic [23:0] sb_q [$];
  int          checks;
  int          failures;

  crash_course_cpu_fetch_controller dut (
    .clk             (clk),
    .rst             (rst),
    .run_req         (run_req),
    .halt_req        (halt_req),
    .step_req        (step_req),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pmem_addr       (pmem_addr),
    .pmem_data       (pmem_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  assign pmem_data = rom[pmem_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] a);
    sb_q.push_back({a, rom[a]});
  endtask

  // Wait (bounded) until the output stage holds the instruction from address a
  task automatic wait_for_pc(input logic [7:0] a, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (inst_valid && inst_pc == a) found = 1'b1;
      else tick();
    end
    if (found) check_eq(tag, {24'd0, inst_pc}, {24'd0, a});
    else       check_eq({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Monitor: every accepted transfer pops the scoreboard and is compared
  always @(negedge clk) begin
    if (!rst && inst_valid && inst_ready && !redirect_valid) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected", {16'd0, inst_data}, 32'hFFFF_FFFF);
      end else begin
        logic [23:0] e;
        e = sb_q.pop_front();
        $display("txn pc=%02h data=%04h exp_pc=%02h exp_data=%04h", inst_pc, inst_data, e[23:16], e[15:0]);
        check_eq("sb_pc", {24'd0, inst_pc}, {24'd0, e[23:16]});
        check_eq("sb_data", {16'd0, inst_data}, {16'd0, e[15:0]});
      end
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[8'h00] = make_inst(OP_LOADIMM, 4'h1, 4'h0, 4'h0);
    rom[8'h01] = make_inst(OP_LOADIMM, 4'h2, 4'h0, 4'h0);
    rom[8'h02] = make_inst(OP_LOADIMM, 4'h3, 4'h0, 4'h1);
    rom[8'h03] = make_inst(OP_LOADIMM, 4'h4, 4'h0, 4'hA);
    rom[8'h04] = make_inst(OP_STORE,   4'h2, 4'h0, 4'h0);
    rom[8'h05] = make_inst(OP_ADD,     4'h1, 4'h2, 4'h3);
    rom[8'h06] = make_inst(OP_ADD,     4'h2, 4'h3, 4'h0);
    rom[8'h07] = make_inst(OP_ADD,     4'h3, 4'h1, 4'h0);
    rom[8'h08] = make_inst(OP_STORE,   4'h1, 4'h0, 4'h1);
    rom[8'h09] = make_inst(OP_ADD,     4'h4, 4'h4, 4'hF);
    rom[8'h0A] = make_inst(OP_STORE,   4'h4, 4'h0, 4'h2);
    rom[8'h0B] = make_inst(OP_JUMP,    4'h0, 4'h0, 4'h5);

    rst = 1'b1;
    run_req = 0; halt_req = 0; step_req = 0;
    redirect_valid = 0; redirect_target = 8'h00; inst_ready = 0;
    tick(); tick();
    rst = 1'b0;

    // Reset state, and nothing fetched without run_req
    check_eq("rst_addr", {24'd0, pmem_addr}, 32'h00);
    check_eq("rst_valid", {31'd0, inst_valid}, 32'd0);
    check_eq("rst_halted", {31'd0, halted}, 32'd1);
    check_eq("rst_count", {16'd0, fetch_count}, 32'd0);
    inst_ready = 1'b1;
    repeat (3) tick();
    check_eq("idle_valid", {31'd0, inst_valid}, 32'd0);
    check_eq("idle_addr", {24'd0, pmem_addr}, 32'h00);

    // Stream 00..0B with one backpressure window at 05
    for (int a = 0; a < 12; a++) push_exp(8'(a));
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    check_eq("run_halted", {31'd0, halted}, 32'd0);
    tick();
    check_eq("first_pc", {24'd0, inst_pc}, 32'h00);
    check_eq("first_data", {16'd0, inst_data}, 32'hA100);
    wait_for_pc(8'h05, "reach_05");
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("bp_valid", {31'd0, inst_valid}, 32'd1);
      check_eq("bp_data", {16'd0, inst_data}, 32'h1123);
      check_eq("bp_pc", {24'd0, inst_pc}, 32'h05);
      check_eq("bp_addr", {24'd0, pmem_addr}, 32'h06);
      check_eq("bp_count", {16'd0, fetch_count}, 32'd6);
    end
    inst_ready = 1'b1;
    wait_for_pc(8'h0B, "reach_0B");
    check_eq("count_0B", {16'd0, fetch_count}, 32'd12);
    check_eq("data_0B", {16'd0, inst_data}, 32'hE005);
    wait_for_pc(8'h0C, "reach_0C");
    check_eq("sb_empty_stream", sb_q.size(), 32'd0);

    // Redirect to 05 flushes the held 0C
    inst_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 8'h05;
    push_exp(8'h05);
    push_exp(8'h06);
    tick();
    redirect_valid = 1'b0;
    inst_ready = 1'b1;
    check_eq("redir_valid", {31'd0, inst_valid}, 32'd0);
    check_eq("redir_addr", {24'd0, pmem_addr}, 32'h05);
    check_eq("redir_halted", {31'd0, halted}, 32'd0);
    tick();
    check_eq("redir_pc", {24'd0, inst_pc}, 32'h05);
    check_eq("redir_data", {16'd0, inst_data}, 32'h1123);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check_eq("halt_halted", {31'd0, halted}, 32'd1);
    check_eq("halt_pc", {24'd0, inst_pc}, 32'h06);
    tick(); tick();
    check_eq("halt_drain", {31'd0, inst_valid}, 32'd0);
    check_eq("halt_addr", {24'd0, pmem_addr}, 32'h07);
    check_eq("sb_empty_redir", sb_q.size(), 32'd0);

    // Single step from HALTED
    push_exp(8'h07);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    check_eq("step_state", {31'd0, halted}, 32'd0);
    tick();
    check_eq("step_pc", {24'd0, inst_pc}, 32'h07);
    check_eq("step_halted", {31'd0, halted}, 32'd1);
    repeat (3) tick();
    check_eq("step_addr", {24'd0, pmem_addr}, 32'h08);
    check_eq("step_count", {16'd0, fetch_count}, 32'd16);
    check_eq("step_valid", {31'd0, inst_valid}, 32'd0);

    // step_req ignored while running
    inst_ready = 1'b0;
    push_exp(8'h08);
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    tick();
    check_eq("run_step_halted", {31'd0, halted}, 32'd0);
    check_eq("run_step_pc", {24'd0, inst_pc}, 32'h08);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check_eq("run_halt", {31'd0, halted}, 32'd1);
    inst_ready = 1'b1;
    tick();

    // halt_req together with run_req keeps it halted
    halt_req = 1'b1;
    run_req = 1'b1;
    tick();
    halt_req = 1'b0;
    run_req = 1'b0;
    tick(); tick();
    check_eq("hr_halted", {31'd0, halted}, 32'd1);
    check_eq("hr_addr", {24'd0, pmem_addr}, 32'h09);
    check_eq("hr_count", {16'd0, fetch_count}, 32'd17);
    check_eq("sb_empty_step", sb_q.size(), 32'd0);

    // PC wrap FF -> 00
    redirect_valid = 1'b1;
    redirect_target = 8'hFF;
    tick();
    redirect_valid = 1'b0;
    check_eq("wrap_addr", {24'd0, pmem_addr}, 32'hFF);
    check_eq("wrap_halted", {31'd0, halted}, 32'd1);
    push_exp(8'hFF);
    push_exp(8'h00);
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    tick();
    check_eq("wrap_ff_pc", {24'd0, inst_pc}, 32'hFF);
    check_eq("wrap_ff_addr", {24'd0, pmem_addr}, 32'h00);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check_eq("wrap_00_pc", {24'd0, inst_pc}, 32'h00);
    check_eq("wrap_00_data", {16'd0, inst_data}, 32'hA100);
    check_eq("wrap_count", {16'd0, fetch_count}, 32'd19);
    tick(); tick();
    check_eq("sb_empty_wrap", sb_q.size(), 32'd0);

    // Asynchronous reset mid-run with an instruction held
    inst_ready = 1'b0;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    tick();
    check_eq("pre_rst_valid", {31'd0, inst_valid}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst_valid", {31'd0, inst_valid}, 32'd0);
    check_eq("arst_addr", {24'd0, pmem_addr}, 32'h00);
    check_eq("arst_halted", {31'd0, halted}, 32'd1);
    check_eq("arst_count", {16'd0, fetch_count}, 32'd0);
    check_eq("arst_data", {16'd0, inst_data}, 32'd0);
    check_eq("arst_pc", {24'd0, inst_pc}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    inst_ready = 1'b1;
    tick();
    check_eq("post_rst_halted", {31'd0, halted}, 32'd1);
    check_eq("post_rst_valid", {31'd0, inst_valid}, 32'd0);
    check_eq("sb_empty_end", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
